// File: rtl/amns_mm_sequencer.sv
// -----------------------------------------------------------------------------
// amns_mm_sequencer
//
// Control sequencer for one AMNS modular multiplication. A single host request
// walks through three phases, each started by a one-cycle pulse and closed by
// a done handshake:
//   load  : memory controller fetches the operands into BRAM
//   mult  : multiplier datapath computes the product
//   store : memory controller writes the result back
// Each wait phase is guarded by a cycle counter; if a phase exceeds TIMEOUT
// cycles the sequencer drops to ERROR, records the phase and returns to IDLE.
//
// The shared BRAM port belongs to the host whenever the sequencer is not busy
// and to the memory controller while an operation is in flight.
//
// Parameters
//   WORD_WIDTH : DSP word width, carried for the surrounding datapath only
//   N          : coefficients per AMNS polynomial
//   S          : WORD_WIDTH blocks per coefficient
//   TIMEOUT    : maximum number of cycles allowed in any wait state
//   AW         : BRAM address width, derived from N and S
//
// Ports
//   clock_i, reset_n_i                  : clock, async active-low reset
//   start_i                             : host request, sampled in IDLE only
//   busy_o, done_o                      : operation in flight / completion pulse
//   error_o, err_phase_o                : sticky timeout flag and failing phase
//                                         (1 = load, 2 = mult, 3 = store)
//   load_start_o / load_done_i          : memory-controller load handshake
//   mm_start_o / mm_done_i              : multiplier handshake
//   store_start_o / store_done_i        : memory-controller store handshake
//   ctl_bram_we_i, ctl_bram_addr_i      : controller BRAM request
//   host_bram_we_i, host_bram_addr_i    : host BRAM request
//   bram_we_o, bram_addr_o              : arbitrated BRAM port
//   host_grant_o                        : host currently owns the BRAM port
//   op_count_o                          : successful operations, wraps at 16 bits
// -----------------------------------------------------------------------------
module amns_mm_sequencer #(
    parameter int WORD_WIDTH = 17,
    parameter int N          = 5,
    parameter int S          = 4,
    parameter int TIMEOUT    = 4095,
    localparam int AW        = $clog2(4*N*S+N)+1
) (
    input  logic          clock_i,
    input  logic          reset_n_i,

    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o,
    output logic [1:0]    err_phase_o,

    output logic          load_start_o,
    input  logic          load_done_i,
    output logic          mm_start_o,
    input  logic          mm_done_i,
    output logic          store_start_o,
    input  logic          store_done_i,

    input  logic          ctl_bram_we_i,
    input  logic [AW-1:0] ctl_bram_addr_i,
    input  logic          host_bram_we_i,
    input  logic [AW-1:0] host_bram_addr_i,
    output logic          bram_we_o,
    output logic [AW-1:0] bram_addr_o,
    output logic          host_grant_o,

    output logic [15:0]   op_count_o
);

    // Counter is wide enough to hold TIMEOUT itself.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT+1) : 1;

    // Reject configurations that cannot describe a real AMNS datapath.
    if (WORD_WIDTH < 1 || N < 1 || S < 1 || TIMEOUT < 1) begin : gParamCheck
        $error("amns_mm_sequencer: WORD_WIDTH, N, S and TIMEOUT must all be positive");
    end

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        WAIT_LOAD,
        MULT,
        WAIT_MULT,
        STORE,
        WAIT_STORE,
        DONE,
        ERROR
    } seqState_e;

    seqState_e       state_q;
    logic [CW-1:0]   waitCnt_q;
    logic [CW-1:0]   waitCnt_d;
    logic            timeoutHit;
    logic            busy_q;
    logic            done_q;
    logic            error_q;
    logic [1:0]      errPhase_q;
    logic            loadStart_q;
    logic            mmStart_q;
    logic            storeStart_q;
    logic [15:0]     opCount_q;

    // The counter holds the number of wait cycles already completed, so the
    // incremented value is the count including the current cycle. The phase
    // times out in the cycle where that count reaches TIMEOUT; a done arriving
    // in that same cycle is checked first and therefore wins.
    always_comb begin
        waitCnt_d  = waitCnt_q + 1'b1;
        timeoutHit = (waitCnt_d == CW'(TIMEOUT));
    end

    // Every output is registered alongside the state, so each pulse lines up
    // with the state it belongs to (e.g. load_start_o is high during LOAD).
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            waitCnt_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            errPhase_q   <= 2'd0;
            loadStart_q  <= 1'b0;
            mmStart_q    <= 1'b0;
            storeStart_q <= 1'b0;
            opCount_q    <= 16'd0;
        end else begin
            loadStart_q  <= 1'b0;
            mmStart_q    <= 1'b0;
            storeStart_q <= 1'b0;
            done_q       <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= LOAD;
                        busy_q      <= 1'b1;
                        loadStart_q <= 1'b1;
                        error_q     <= 1'b0;
                        errPhase_q  <= 2'd0;
                    end
                end

                LOAD: begin
                    state_q   <= WAIT_LOAD;
                    waitCnt_q <= '0;
                end

                WAIT_LOAD: begin
                    if (load_done_i) begin
                        state_q   <= MULT;
                        mmStart_q <= 1'b1;
                    end else if (timeoutHit) begin
                        state_q    <= ERROR;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        errPhase_q <= 2'd1;
                    end else begin
                        waitCnt_q <= waitCnt_d;
                    end
                end

                MULT: begin
                    state_q   <= WAIT_MULT;
                    waitCnt_q <= '0;
                end

                WAIT_MULT: begin
                    if (mm_done_i) begin
                        state_q      <= STORE;
                        storeStart_q <= 1'b1;
                    end else if (timeoutHit) begin
                        state_q    <= ERROR;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        errPhase_q <= 2'd2;
                    end else begin
                        waitCnt_q <= waitCnt_d;
                    end
                end

                STORE: begin
                    state_q   <= WAIT_STORE;
                    waitCnt_q <= '0;
                end

                WAIT_STORE: begin
                    if (store_done_i) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        opCount_q <= opCount_q + 16'd1;
                    end else if (timeoutHit) begin
                        state_q    <= ERROR;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        errPhase_q <= 2'd3;
                    end else begin
                        waitCnt_q <= waitCnt_d;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                ERROR: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Grant is derived from registered busy; the data path through the mux
    // stays combinational so the owner sees its request on the port at once.
    assign host_grant_o = ~busy_q;
    assign bram_we_o    = host_grant_o ? host_bram_we_i   : ctl_bram_we_i;
    assign bram_addr_o  = host_grant_o ? host_bram_addr_i : ctl_bram_addr_i;

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign err_phase_o   = errPhase_q;
    assign load_start_o  = loadStart_q;
    assign mm_start_o    = mmStart_q;
    assign store_start_o = storeStart_q;
    assign op_count_o    = opCount_q;

endmodule

// File: tb/tb_amns_mm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_amns_mm_sequencer
//
// Directed bench for amns_mm_sequencer. Two instances share every input except
// start: dutA keeps the default TIMEOUT for the long nominal run, dutB uses
// TIMEOUT = 15 for the timeout scenarios. A sequencer outside its wait states
// ignores the shared done inputs, so each instance is exercised while the
// other sits in IDLE.
// -----------------------------------------------------------------------------
module tb_amns_mm_sequencer;

    localparam int AW = $clog2(4*5*4+5)+1;

    logic          clock;
    logic          resetN;
    logic          startA;
    logic          startB;
    logic          loadDone;
    logic          mmDone;
    logic          storeDone;
    logic          ctlWe;
    logic [AW-1:0] ctlAddr;
    logic          hostWe;
    logic [AW-1:0] hostAddr;

    logic          busyA, doneA, errorA, loadStartA, mmStartA, storeStartA;
    logic          bramWeA, hostGrantA;
    logic [1:0]    errPhaseA;
    logic [AW-1:0] bramAddrA;
    logic [15:0]   opCountA;

    logic          busyB, doneB, errorB, loadStartB, mmStartB, storeStartB;
    logic          bramWeB, hostGrantB;
    logic [1:0]    errPhaseB;
    logic [AW-1:0] bramAddrB;
    logic [15:0]   opCountB;

    int compared   = 0;
    int mismatched = 0;

    int loadPulsesA  = 0;
    int mmPulsesA    = 0;
    int storePulsesA = 0;
    int donePulsesA  = 0;
    int storePulsesB = 0;

    int lp0, mp0, sp0, dp0, spB0;

    amns_mm_sequencer dutA (
        .clock_i          (clock),
        .reset_n_i        (resetN),
        .start_i          (startA),
        .busy_o           (busyA),
        .done_o           (doneA),
        .error_o          (errorA),
        .err_phase_o      (errPhaseA),
        .load_start_o     (loadStartA),
        .load_done_i      (loadDone),
        .mm_start_o       (mmStartA),
        .mm_done_i        (mmDone),
        .store_start_o    (storeStartA),
        .store_done_i     (storeDone),
        .ctl_bram_we_i    (ctlWe),
        .ctl_bram_addr_i  (ctlAddr),
        .host_bram_we_i   (hostWe),
        .host_bram_addr_i (hostAddr),
        .bram_we_o        (bramWeA),
        .bram_addr_o      (bramAddrA),
        .host_grant_o     (hostGrantA),
        .op_count_o       (opCountA)
    );

    amns_mm_sequencer #(.TIMEOUT(15)) dutB (
        .clock_i          (clock),
        .reset_n_i        (resetN),
        .start_i          (startB),
        .busy_o           (busyB),
        .done_o           (doneB),
        .error_o          (errorB),
        .err_phase_o      (errPhaseB),
        .load_start_o     (loadStartB),
        .load_done_i      (loadDone),
        .mm_start_o       (mmStartB),
        .mm_done_i        (mmDone),
        .store_start_o    (storeStartB),
        .store_done_i     (storeDone),
        .ctl_bram_we_i    (ctlWe),
        .ctl_bram_addr_i  (ctlAddr),
        .host_bram_we_i   (hostWe),
        .host_bram_addr_i (hostAddr),
        .bram_we_o        (bramWeB),
        .bram_addr_o      (bramAddrB),
        .host_grant_o     (hostGrantB),
        .op_count_o       (opCountB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count cycles each start/done output is high, sampled mid-cycle.
    always @(negedge clock) begin
        if (loadStartA)  loadPulsesA  <= loadPulsesA + 1;
        if (mmStartA)    mmPulsesA    <= mmPulsesA + 1;
        if (storeStartA) storePulsesA <= storePulsesA + 1;
        if (doneA)       donePulsesA  <= donePulsesA + 1;
        if (storeStartB) storePulsesB <= storePulsesB + 1;
    end

    // Advance the given number of cycles, landing 1 ns after the rising edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Full operation with immediate done responses; returns in the DONE cycle.
    task automatic runQuick(input bit useA);
        if (useA) startA = 1'b1; else startB = 1'b1;
        applyStimulus(1);
        startA = 1'b0;
        startB = 1'b0;
        applyStimulus(1);
        loadDone = 1'b1;
        applyStimulus(1);
        loadDone = 1'b0;
        applyStimulus(1);
        mmDone = 1'b1;
        applyStimulus(1);
        mmDone = 1'b0;
        applyStimulus(1);
        storeDone = 1'b1;
        applyStimulus(1);
        storeDone = 1'b0;
    endtask

    initial begin
        resetN    = 1'b1;
        startA    = 1'b0;
        startB    = 1'b0;
        loadDone  = 1'b0;
        mmDone    = 1'b0;
        storeDone = 1'b0;
        ctlWe     = 1'b0;
        ctlAddr   = 8'd3;
        hostWe    = 1'b1;
        hostAddr  = 8'd7;
        #1 resetN = 1'b0;
        applyStimulus(2);

        $display("[TB] reset state");
        checkOutput("rst_busyA",       32'(busyA),       0);
        checkOutput("rst_doneA",       32'(doneA),       0);
        checkOutput("rst_errorA",      32'(errorA),      0);
        checkOutput("rst_errPhaseA",   32'(errPhaseA),   0);
        checkOutput("rst_opCountA",    32'(opCountA),    0);
        checkOutput("rst_hostGrantA",  32'(hostGrantA),  1);
        checkOutput("rst_loadStartA",  32'(loadStartA),  0);
        checkOutput("rst_mmStartA",    32'(mmStartA),    0);
        checkOutput("rst_storeStartA", 32'(storeStartA), 0);
        checkOutput("rst_bramAddrA",   32'(bramAddrA),   7);
        checkOutput("rst_bramWeA",     32'(bramWeA),     1);
        checkOutput("rst_hostGrantB",  32'(hostGrantB),  1);

        resetN = 1'b1;
        applyStimulus(1);

        $display("[TB] nominal run 105/50/20 on dutA");
        lp0 = loadPulsesA; mp0 = mmPulsesA; sp0 = storePulsesA; dp0 = donePulsesA;
        startA = 1'b1;
        applyStimulus(1);
        startA = 1'b0;
        checkOutput("lat_loadStartA",  32'(loadStartA), 1);
        checkOutput("lat_busyA",       32'(busyA),      1);
        checkOutput("lat_hostGrantA",  32'(hostGrantA), 0);
        applyStimulus(1);
        checkOutput("waitload_loadStartA", 32'(loadStartA), 0);
        for (int i = 0; i < 105; i++) begin
            ctlAddr  = AW'(i);
            ctlWe    = i[0];
            hostWe   = 1'b1;
            hostAddr = 8'd7;
            #1;
            checkOutput("mux_bramAddrA",  32'(bramAddrA),  32'(i));
            checkOutput("mux_bramWeA",    32'(bramWeA),    32'(i[0]));
            checkOutput("mux_hostGrantA", 32'(hostGrantA), 0);
            checkOutput("mux_busyA",      32'(busyA),      1);
            applyStimulus(1);
        end
        ctlWe    = 1'b0;
        loadDone = 1'b1;
        applyStimulus(1);
        loadDone = 1'b0;
        checkOutput("mult_mmStartA", 32'(mmStartA), 1);
        checkOutput("mult_busyA",    32'(busyA),    1);
        applyStimulus(10);
        startA = 1'b1;
        applyStimulus(1);
        startA = 1'b0;
        applyStimulus(39);
        checkOutput("waitmult_busyA",      32'(busyA),      1);
        checkOutput("busystart_loadStartA", 32'(loadStartA), 0);
        mmDone = 1'b1;
        applyStimulus(1);
        mmDone = 1'b0;
        checkOutput("store_storeStartA", 32'(storeStartA), 1);
        applyStimulus(20);
        checkOutput("waitstore_busyA", 32'(busyA), 1);
        checkOutput("waitstore_doneA", 32'(doneA), 0);
        storeDone = 1'b1;
        applyStimulus(1);
        storeDone = 1'b0;
        checkOutput("done_doneA",      32'(doneA),      1);
        checkOutput("done_opCountA",   32'(opCountA),   1);
        checkOutput("done_busyA",      32'(busyA),      0);
        checkOutput("done_hostGrantA", 32'(hostGrantA), 1);
        checkOutput("done_errorA",     32'(errorA),     0);
        applyStimulus(1);
        checkOutput("idle_doneA", 32'(doneA), 0);
        checkOutput("pulses_loadA",  32'(loadPulsesA - lp0),  1);
        checkOutput("pulses_mmA",    32'(mmPulsesA - mp0),    1);
        checkOutput("pulses_storeA", 32'(storePulsesA - sp0), 1);
        checkOutput("pulses_doneA",  32'(donePulsesA - dp0),  1);

        $display("[TB] stray load_done in IDLE");
        loadDone = 1'b1;
        applyStimulus(2);
        loadDone = 1'b0;
        checkOutput("stray_busyA",    32'(busyA),    0);
        checkOutput("stray_mmStartA", 32'(mmStartA), 0);
        checkOutput("stray_busyB",    32'(busyB),    0);

        $display("[TB] mult timeout on dutB");
        spB0 = storePulsesB;
        startB = 1'b1;
        applyStimulus(1);
        startB = 1'b0;
        checkOutput("to_loadStartB", 32'(loadStartB), 1);
        applyStimulus(1);
        loadDone = 1'b1;
        applyStimulus(1);
        loadDone = 1'b0;
        checkOutput("to_mmStartB", 32'(mmStartB), 1);
        applyStimulus(1);
        applyStimulus(14);
        checkOutput("to_wait15_busyB",  32'(busyB),  1);
        checkOutput("to_wait15_errorB", 32'(errorB), 0);
        applyStimulus(1);
        checkOutput("to_errorB",     32'(errorB),     1);
        checkOutput("to_errPhaseB",  32'(errPhaseB),  2);
        checkOutput("to_busyB",      32'(busyB),      0);
        checkOutput("to_doneB",      32'(doneB),      0);
        checkOutput("to_hostGrantB", 32'(hostGrantB), 1);
        applyStimulus(1);
        checkOutput("to_sticky_errorB",    32'(errorB),    1);
        checkOutput("to_sticky_errPhaseB", 32'(errPhaseB), 2);
        checkOutput("to_storePulsesB",     32'(storePulsesB - spB0), 0);

        $display("[TB] store_done on 15th wait cycle on dutB");
        startB = 1'b1;
        applyStimulus(1);
        startB = 1'b0;
        checkOutput("clr_errorB",     32'(errorB),     0);
        checkOutput("clr_errPhaseB",  32'(errPhaseB),  0);
        checkOutput("clr_loadStartB", 32'(loadStartB), 1);
        applyStimulus(1);
        loadDone = 1'b1;
        applyStimulus(1);
        loadDone = 1'b0;
        applyStimulus(1);
        mmDone = 1'b1;
        applyStimulus(1);
        mmDone = 1'b0;
        checkOutput("edge_storeStartB", 32'(storeStartB), 1);
        applyStimulus(1);
        applyStimulus(14);
        storeDone = 1'b1;
        applyStimulus(1);
        storeDone = 1'b0;
        checkOutput("edge_doneB",    32'(doneB),    1);
        checkOutput("edge_errorB",   32'(errorB),   0);
        checkOutput("edge_busyB",    32'(busyB),    0);
        checkOutput("edge_opCountB", 32'(opCountB), 1);
        applyStimulus(1);

        $display("[TB] reset during WAIT_STORE on dutB");
        startB = 1'b1;
        applyStimulus(1);
        startB = 1'b0;
        applyStimulus(1);
        loadDone = 1'b1;
        applyStimulus(1);
        loadDone = 1'b0;
        applyStimulus(1);
        mmDone = 1'b1;
        applyStimulus(1);
        mmDone = 1'b0;
        applyStimulus(4);
        checkOutput("mid_busyB",      32'(busyB),      1);
        checkOutput("mid_hostGrantB", 32'(hostGrantB), 0);
        #2 resetN = 1'b0;
        #1;
        checkOutput("arst_busyB",       32'(busyB),       0);
        checkOutput("arst_hostGrantB",  32'(hostGrantB),  1);
        checkOutput("arst_doneB",       32'(doneB),       0);
        checkOutput("arst_errorB",      32'(errorB),      0);
        checkOutput("arst_opCountB",    32'(opCountB),    0);
        checkOutput("arst_storeStartB", 32'(storeStartB), 0);
        checkOutput("arst_bramAddrB",   32'(bramAddrB),   7);
        applyStimulus(1);
        resetN    = 1'b1;
        storeDone = 1'b1;
        applyStimulus(2);
        storeDone = 1'b0;
        checkOutput("post_rst_doneB", 32'(doneB), 0);
        checkOutput("post_rst_busyB", 32'(busyB), 0);
        runQuick(1'b0);
        checkOutput("rerun_doneB",    32'(doneB),    1);
        checkOutput("rerun_opCountB", 32'(opCountB), 1);
        applyStimulus(1);

        $display("[TB] op_count wrap on dutA");
        force dutA.opCount_q = 16'hFFFF;
        applyStimulus(1);
        release dutA.opCount_q;
        checkOutput("wrap_preload_opCountA", 32'(opCountA), 32'hFFFF);
        runQuick(1'b1);
        checkOutput("wrap_doneA",    32'(doneA),    1);
        checkOutput("wrap_opCountA", 32'(opCountA), 0);
        applyStimulus(1);
        checkOutput("wrap_idle_busyA", 32'(busyA), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/amns_mm_sequencer.md
AMNS_MM_SEQUENCER -- requirements
Module: amns_mm_sequencer

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 17, DSP word width (pass-through only, no internal use).
REQ-002 The block SHALL have parameter N, default 5, coefficients per AMNS polynomial.
REQ-003 The block SHALL have parameter S, default 4, WORD_WIDTH blocks per coefficient.
REQ-004 The block SHALL have parameter TIMEOUT, default 4095, max cycles allowed in any wait state.
REQ-005 The block SHALL use derived width AW = $clog2(4*N*S+N)+1 for all BRAM address ports.
REQ-006 clock_i  in  1  single clock, all state on rising edge.
REQ-007 reset_n_i  in  1  reset, asynchronous, active-low.
REQ-008 start_i  in  1  host request for one full load/multiply/store operation; sampled only in IDLE.
REQ-009 busy_o  out  1  high from the cycle after start is accepted until the DONE or ERROR state.
REQ-010 done_o  out  1  one-cycle pulse on successful completion.
REQ-011 error_o  out  1  sticky phase-timeout flag, cleared by the next accepted start_i.
REQ-012 err_phase_o  out  2  phase that timed out: 1=load, 2=mult, 3=store; 0 if no error.
REQ-013 load_start_o / load_done_i  out/in  1/1  memory-controller load handshake.
REQ-014 mm_start_o / mm_done_i  out/in  1/1  multiplier datapath handshake.
REQ-015 store_start_o / store_done_i  out/in  1/1  memory-controller store handshake.
REQ-016 ctl_bram_we_i, ctl_bram_addr_i  in  1, AW  BRAM port request from the memory controller.
REQ-017 host_bram_we_i, host_bram_addr_i  in  1, AW  BRAM port request from the host.
REQ-018 bram_we_o, bram_addr_o  out  1, AW  arbitrated BRAM port.
REQ-019 host_grant_o  out  1  high when the host owns the BRAM port.
REQ-020 op_count_o  out  16  count of successful operations, wraps 0xFFFF->0.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, WAIT_LOAD, MULT, WAIT_MULT, STORE, WAIT_STORE, DONE, ERROR.
REQ-022 IDLE->LOAD on start_i=1; LOAD, MULT and STORE SHALL each last exactly one cycle and then go to their WAIT_x state.
REQ-023 load_start_o, mm_start_o and store_start_o SHALL be registered and high for exactly one cycle, during LOAD, MULT and STORE respectively.
REQ-024 WAIT_LOAD->MULT on load_done_i; WAIT_MULT->STORE on mm_done_i; WAIT_STORE->DONE on store_done_i.
REQ-025 A done input asserted outside its own wait state SHALL be ignored.
REQ-026 DONE SHALL last one cycle, assert done_o, increment op_count_o, and return to IDLE.
REQ-027 A wait-cycle counter SHALL clear on entering each WAIT_x state and increment each cycle in it.
REQ-028 When the counter equals TIMEOUT without the matching done, the FSM SHALL go to ERROR, set error_o and load err_phase_o.
REQ-029 If the done input arrives in the same cycle the counter reaches TIMEOUT, done SHALL win.
REQ-030 ERROR SHALL last one cycle and then go to IDLE; op_count_o SHALL NOT increment.
REQ-031 busy_o SHALL be high in LOAD through WAIT_STORE and low in IDLE, DONE and ERROR.
REQ-032 host_grant_o SHALL equal !busy_o.
REQ-033 When host_grant_o=1, bram_we_o/bram_addr_o SHALL equal the host inputs; otherwise they SHALL equal the ctl inputs.
REQ-034 The BRAM mux SHALL be combinational; the grant select SHALL be registered state.
REQ-035 Host BRAM requests while not granted SHALL be dropped: bram_we_o follows ctl only.
REQ-036 start_i while busy SHALL be ignored, with no queuing.
REQ-037 Latency: start_i at cycle t gives load_start_o at t+1; store_done_i at cycle u gives done_o at u+1.

Reset
REQ-038 On reset_n_i=0, the FSM SHALL go to IDLE asynchronously, with busy_o, done_o, error_o, all *_start_o =0, err_phase_o=0, op_count_o=0, wait counter=0, host_grant_o=1.
REQ-039 Reset mid-operation SHALL abort immediately with no done_o pulse; the host regains the BRAM port.

Verification
REQ-040 N=5,S=4: start_i pulse; load_done_i after 105 cycles, mm_done_i after 50, store_done_i after 20 -> one pulse on each start output, done_o once, op_count_o=1, busy_o high throughout.
REQ-041 During WAIT_LOAD, drive ctl addr 0..104 and host_bram_we_i=1, host addr 7 -> bram_addr_o follows ctl, bram_we_o=ctl_bram_we_i, host_grant_o=0.
REQ-042 TIMEOUT=15, mm_done_i never asserted -> ERROR exactly 15 cycles after entering WAIT_MULT, error_o=1, err_phase_o=2, no store_start_o; next start_i clears error_o.
REQ-043 TIMEOUT=15, store_done_i on the 15th wait cycle -> DONE, not ERROR; error_o stays 0.
REQ-044 reset_n_i low during WAIT_STORE -> all outputs at reset values within the same cycle; a later start_i runs normally.
REQ-045 Preload op_count_o=0xFFFF via 65535 runs, or force in sim, then one run -> op_count_o=0; stray load_done_i in IDLE -> no state change.
